time_tmr_opgroup_sched: RTL and testbench
=========================================

TIME_TMR_OPGROUP_SCHED -- requirements
Module: time_tmr_opgroup_sched

Interface
REQ-001 SHALL have parameter NumOpgroups, default 3: number of requesting operation groups (>=2).
REQ-002 SHALL have parameter DataWidth, default 8: payload width in bits.
REQ-003 SHALL have parameter IDSize, default 4: transaction ID width in bits.
REQ-004 SHALL have parameter LockTimeout, default 5: stall cycles before a timeout pulse (>=1).
REQ-005 SHALL have derived parameter OpgroupWidth = max(1, clog2(NumOpgroups)).
REQ-006 SHALL have port clk_i, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-007 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port req_valid_i, input, NumOpgroups bits: per-opgroup request valid.
REQ-009 SHALL have port req_data_i, input, NumOpgroups*DataWidth bits: per-opgroup payload, with opgroup g at bits [g*DataWidth +: DataWidth].
REQ-010 SHALL have port req_ready_o, output, NumOpgroups bits: per-opgroup accept.
REQ-011 SHALL have port data_o, output, DataWidth bits: replicated payload.
REQ-012 SHALL have port opgroup_o, output, OpgroupWidth bits: index of the owning opgroup.
REQ-013 SHALL have port id_o, output, IDSize bits: transaction ID shared by all three replicas.
REQ-014 SHALL have port replica_o, output, 2 bits: replica index 0, 1 or 2.
REQ-015 SHALL have port valid_o, output, 1 bit: downstream valid.
REQ-016 SHALL have port ready_i, input, 1 bit: downstream ready.
REQ-017 SHALL have port busy_o, output, 1 bit: high whenever state is not IDLE.
REQ-018 SHALL have port lock_timeout_o, output, 1 bit: one-cycle stall-timeout pulse.

Function
REQ-019 SHALL implement states IDLE, SEND0, SEND1 and SEND2.
REQ-020 In IDLE, SHALL grant round-robin among set req_valid_i bits, starting the search at pointer rr and wrapping NumOpgroups-1 -> 0.
REQ-021 SHALL assert req_ready_o[g] only in IDLE and only for the granted g, combinationally from req_valid_i; all other bits SHALL be 0.
REQ-022 On an upstream handshake, SHALL capture the payload, g and the current ID counter into output registers, then move to SEND0.
REQ-023 SHALL drive valid_o=1 from the cycle after capture (1-cycle latency); valid_o SHALL be 0 in IDLE.
REQ-024 In SENDk, SHALL drive replica_o=k.
REQ-025 In SENDk, SHALL hold data_o, opgroup_o and id_o stable until valid_o&&ready_i, then advance to SEND(k+1), or from SEND2 to IDLE.
REQ-026 SHALL keep the lock: no new grant until the SEND2 handshake, regardless of other requests.
REQ-027 On the SEND2 handshake, SHALL increment the ID counter modulo 2^IDSize (e.g. 15 -> 0 for IDSize=4) and set rr = (g+1) mod NumOpgroups.
REQ-028 SHALL insert exactly one IDLE cycle between triples, giving a peak throughput of 1 element per 4 cycles.
REQ-029 SHALL count consecutive cycles with valid_o && !ready_i; the count SHALL reset on any handshake or in IDLE.
REQ-030 When the stall count reaches LockTimeout, SHALL pulse lock_timeout_o for one cycle and restart the count from 0, while still holding valid_o and the payload.
REQ-031 With no requests, SHALL remain in IDLE with rr unchanged.
REQ-032 When a single requester is continuously valid, SHALL serve it on every IDLE visit.

Reset
REQ-033 While rst_i=1, SHALL asynchronously force state IDLE, and set valid_o, data_o, opgroup_o, id_o, replica_o, req_ready_o, busy_o, lock_timeout_o, rr, the ID counter and the stall counter to 0.
REQ-034 A reset mid-triple SHALL discard the element in flight without completing its remaining replicas.
REQ-035 SHALL return to normal operation on the first rising clk_i edge after rst_i deasserts.

Verification
REQ-036 Opgroup 1 sends 0xA5 with ready_i=1 -> replicas 0, 1, 2 are output with data 0xA5, opgroup 1, id 0 on consecutive cycles, then busy_o=0.
REQ-037 All three opgroups stay valid with ready_i=1 -> grants follow 0, 1, 2, 0; each ID increments; each triple is contiguous.
REQ-038 ready_i=0 for 12 cycles during SEND1 -> lock_timeout_o pulses at stall cycles 5 and 10, and the payload and replica_o=1 stay stable.
REQ-039 rst_i is asserted during SEND1 -> outputs go to 0 immediately; after release, the next request gets id 0, replica 0.
REQ-040 A run of 17 transactions -> id_o wraps 15 -> 0 at the 17th transaction.
REQ-041 Opgroup 2 raises valid during opgroup 0's SEND1 -> req_ready_o[2] stays 0 until after opgroup 0's SEND2 handshake.

Source files
------------

// File: rtl/time_tmr_opgroup_sched.sv
// Round-robin opgroup arbiter that emits every accepted element three times
// (TMR replicas 0..2) under a shared ID, holding the lock until the last replica drains.
module time_tmr_opgroup_sched #(
  parameter int NumOpgroups  = 3,
  parameter int DataWidth    = 8,
  parameter int IDSize       = 4,
  parameter int LockTimeout  = 5,
  localparam int OpgroupWidth = ($clog2(NumOpgroups) > 1) ? $clog2(NumOpgroups) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NumOpgroups-1:0]           req_valid_i,
  input  logic [NumOpgroups*DataWidth-1:0] req_data_i,
  output logic [NumOpgroups-1:0]           req_ready_o,
  output logic [DataWidth-1:0]             data_o,
  output logic [OpgroupWidth-1:0]          opgroup_o,
  output logic [IDSize-1:0]                id_o,
  output logic [1:0]                       replica_o,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic                             busy_o,
  output logic                             lock_timeout_o
);

  localparam int CntW = $clog2(LockTimeout + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SEND0 = 2'd1, SEND1 = 2'd2, SEND2 = 2'd3} state_t;

  typedef struct packed {
    logic [DataWidth-1:0]    data;
    logic [OpgroupWidth-1:0] opgroup;
    logic [IDSize-1:0]       id;
  } elem_t;

  state_t                                 state, state_nxt;
  elem_t                                  elem;
  logic [NumOpgroups-1:0][DataWidth-1:0]  req_data;
  logic [OpgroupWidth-1:0]                rr, gnt_idx, scan;
  logic                                   gnt_vld, up_hs, last_hs, stall;
  logic [IDSize-1:0]                      id_cnt;
  logic [CntW-1:0]                        stall_cnt;

  assign req_data = req_data_i;

  // First set valid bit at or after rr, wrapping past the last opgroup.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    scan    = rr;
    for (int i = 0; i < NumOpgroups; i++) begin
      if (req_valid_i[scan] && !gnt_vld) begin
        gnt_vld = 1'b1;
        gnt_idx = scan;
      end
      scan = (scan == OpgroupWidth'(NumOpgroups - 1)) ? '0 : scan + OpgroupWidth'(1);
    end
  end

  assign up_hs   = (state == IDLE) && gnt_vld;
  assign last_hs = (state == SEND2) && ready_i;
  assign stall   = valid_o && !ready_i;

  always_comb begin
    req_ready_o = '0;
    if (up_hs && !rst_i) req_ready_o[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    replica_o = 2'd0;
    case (state)
      IDLE:  if (gnt_vld) state_nxt = SEND0;
      SEND0: if (ready_i) state_nxt = SEND1;
      SEND1: begin
        replica_o = 2'd1;
        if (ready_i) state_nxt = SEND2;
      end
      SEND2: begin
        replica_o = 2'd2;
        if (ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      elem   <= '0;
      rr     <= '0;
      id_cnt <= '0;
    end else begin
      if (up_hs) elem <= '{data: req_data[gnt_idx], opgroup: gnt_idx, id: id_cnt};
      if (last_hs) begin
        id_cnt <= id_cnt + IDSize'(1);
        rr     <= (elem.opgroup == OpgroupWidth'(NumOpgroups - 1)) ?
                  '0 : elem.opgroup + OpgroupWidth'(1);
      end
    end
  end

  // Stall watchdog: the pulse lands in the cycle after the LockTimeout-th stalled cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt      <= '0;
      lock_timeout_o <= 1'b0;
    end else begin
      lock_timeout_o <= 1'b0;
      if (!stall) begin
        stall_cnt <= '0;
      end else if (stall_cnt == CntW'(LockTimeout - 1)) begin
        stall_cnt      <= '0;
        lock_timeout_o <= 1'b1;
      end else begin
        stall_cnt <= stall_cnt + CntW'(1);
      end
    end
  end

  assign valid_o   = (state != IDLE);
  assign busy_o    = (state != IDLE);
  assign data_o    = elem.data;
  assign opgroup_o = elem.opgroup;
  assign id_o      = elem.id;

endmodule

// File: tb/tb_time_tmr_opgroup_sched.sv
// Scoreboard bench: every accepted request queues its three expected replicas,
// a negedge monitor pops and compares them on each downstream handshake.
module tb_time_tmr_opgroup_sched;
  localparam int N  = 3;
  localparam int DW = 8;
  localparam int IW = 4;
  localparam int LT = 5;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [N-1:0]    req_valid_i;
  logic [N*DW-1:0] req_data_i;
  logic [N-1:0]    req_ready_o;
  logic [DW-1:0]   data_o;
  logic [1:0]      opgroup_o;
  logic [IW-1:0]   id_o;
  logic [1:0]      replica_o;
  logic            valid_o, ready_i, busy_o, lock_timeout_o;

  time_tmr_opgroup_sched #(.NumOpgroups(N), .DataWidth(DW), .IDSize(IW), .LockTimeout(LT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .data_o(data_o), .opgroup_o(opgroup_o), .id_o(id_o),
    .replica_o(replica_o), .valid_o(valid_o), .ready_i(ready_i), .busy_o(busy_o),
    .lock_timeout_o(lock_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [DW-1:0] d;
    logic [1:0]    g;
    logic [IW-1:0] id;
    logic [1:0]    rep;
  } exp_t;

  exp_t          sbq[$];
  exp_t          e;
  logic [IW-1:0] exp_id;
  int            n_chk = 0;
  int            n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_triple(input logic [1:0] g, input logic [DW-1:0] d);
    for (int r = 0; r < 3; r++) sbq.push_back('{d: d, g: g, id: exp_id, rep: 2'(r)});
    exp_id++;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    req_valid_i = '0;
    tick();
    tick();
    rst_i = 1'b0;
    exp_id = '0;
    sbq.delete();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sbq.size() != 0 || busy_o) && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 32'(sbq.size() == 0 && !busy_o), 32'd1);
  endtask

  always @(negedge clk_i) begin
    if (!rst_i && valid_o && ready_i) begin
      chk("sb_has_entry", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("data",    32'(data_o),    32'(e.d));
        chk("opgroup", 32'(opgroup_o), 32'(e.g));
        chk("id",      32'(id_o),      32'(e.id));
        chk("replica", 32'(replica_o), 32'(e.rep));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    ready_i = 1'b1;
    req_data_i = '0;
    req_valid_i = '1;
    exp_id = '0;
    tick();
    tick();
    // Reset state with every requester asking.
    chk("rst_req_ready", 32'(req_ready_o), 32'd0);
    chk("rst_valid",     32'(valid_o),     32'd0);
    chk("rst_busy",      32'(busy_o),      32'd0);
    chk("rst_data",      32'(data_o),      32'd0);
    chk("rst_id",        32'(id_o),        32'd0);
    chk("rst_replica",   32'(replica_o),   32'd0);
    chk("rst_opgroup",   32'(opgroup_o),   32'd0);
    chk("rst_timeout",   32'(lock_timeout_o), 32'd0);
    rst_i = 1'b0;
    req_valid_i = '0;
    tick();

    // Single element from opgroup 1.
    req_data_i = {8'h00, 8'hA5, 8'h00};
    req_valid_i = 3'b010;
    push_triple(2'd1, 8'hA5);
    #1 chk("t2_req_ready", 32'(req_ready_o), 32'b010);
    tick();
    req_valid_i = '0;
    for (int k = 0; k < 3; k++) begin
      chk("t2_valid", 32'(valid_o), 32'd1);
      tick();
    end
    chk("t2_busy_after", 32'(busy_o), 32'd0);
    drain("t2_drain");

    // All three requesting: grants 0,1,2,0 on a 4-cycle cadence.
    do_reset();
    req_data_i = {8'h32, 8'h21, 8'h10};
    req_valid_i = 3'b111;
    push_triple(2'd0, 8'h10);
    push_triple(2'd1, 8'h21);
    push_triple(2'd2, 8'h32);
    push_triple(2'd0, 8'h10);
    #1 chk("t3_req_ready", 32'(req_ready_o), 32'b001);
    repeat (13) tick();
    req_valid_i = '0;
    drain("t3_drain");

    // Long stall in SEND1.
    do_reset();
    req_data_i = {8'h00, 8'h00, 8'h5C};
    req_valid_i = 3'b001;
    push_triple(2'd0, 8'h5C);
    tick();
    req_valid_i = '0;
    tick();
    ready_i = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      chk("t4_timeout", 32'(lock_timeout_o), 32'(k == 6 || k == 11));
      chk("t4_data",    32'(data_o),    32'h5C);
      chk("t4_replica", 32'(replica_o), 32'd1);
      chk("t4_valid",   32'(valid_o),   32'd1);
      tick();
    end
    ready_i = 1'b1;
    drain("t4_drain");

    // Reset mid-triple; the in-flight element carries id 1.
    req_data_i = {8'h3C, 8'h77, 8'h00};
    req_valid_i = 3'b100;
    sbq.push_back('{d: 8'h3C, g: 2'd2, id: exp_id, rep: 2'd0});
    tick();
    req_valid_i = '0;
    tick();
    chk("t5_pre_replica", 32'(replica_o), 32'd1);
    rst_i = 1'b1;
    #1;
    chk("t5_valid",   32'(valid_o),   32'd0);
    chk("t5_busy",    32'(busy_o),    32'd0);
    chk("t5_data",    32'(data_o),    32'd0);
    chk("t5_id",      32'(id_o),      32'd0);
    chk("t5_replica", 32'(replica_o), 32'd0);
    chk("t5_opgroup", 32'(opgroup_o), 32'd0);
    tick();
    tick();
    rst_i = 1'b0;
    exp_id = '0;
    chk("t5_sb_empty", 32'(sbq.size()), 32'd0);
    req_valid_i = 3'b010;
    push_triple(2'd1, 8'h77);
    tick();
    req_valid_i = '0;
    drain("t5_drain");

    // 17 back-to-back transactions from one requester: id wraps 15 -> 0.
    do_reset();
    req_data_i = {8'h00, 8'h00, 8'h4D};
    req_valid_i = 3'b001;
    repeat (17) push_triple(2'd0, 8'h4D);
    repeat (65) tick();
    req_valid_i = '0;
    drain("t6_drain");

    // Opgroup 2 arrives during opgroup 0's triple and must wait for the lock.
    do_reset();
    req_data_i = {8'h99, 8'h00, 8'h11};
    req_valid_i = 3'b001;
    push_triple(2'd0, 8'h11);
    #1 chk("t7_ready_idle", 32'(req_ready_o), 32'b001);
    tick();
    req_valid_i = '0;
    #1 chk("t7_ready_send0", 32'(req_ready_o), 32'd0);
    tick();
    req_valid_i = 3'b100;
    push_triple(2'd2, 8'h99);
    #1 chk("t7_ready_send1", 32'(req_ready_o), 32'd0);
    tick();
    #1 chk("t7_ready_send2", 32'(req_ready_o), 32'd0);
    tick();
    #1 chk("t7_ready_grant2", 32'(req_ready_o), 32'b100);
    tick();
    req_valid_i = '0;
    drain("t7_drain");

    // Idle with no requests keeps rr at 0 (after opgroup 2), so 0 wins over 1.
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t8_idle_busy", 32'(busy_o), 32'd0);
    end
    req_valid_i = 3'b011;
    #1 chk("t8_rr_kept", 32'(req_ready_o), 32'b001);
    req_valid_i = '0;
    tick();
    chk("t8_no_grant", 32'(busy_o), 32'd0);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
